// File: rtl/tl_ram_responder.sv
// TileLink-UL manager endpoint backed by a small word-addressed register array.
// Requests are serviced at the A fire edge and answered through a 2-entry in-order response queue.
`timescale 1ns/1ps
module tl_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [1:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [1:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } rsp_t;

  rsp_t        fifo_q [2];
  rsp_t        fifo_d [2];
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        ready_en_q;

  logic        a_fire, d_fire, in_range, aligned, legal;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  rsp_t        rsp, head;
  logic        unused;

  assign unused = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt, offset[31:AW+2]};

  // ready_en_q keeps a_ready low until the first edge after reset release.
  assign auto_in_a_ready = ready_en_q & (count_q != 2'd2);
  assign a_fire = auto_in_a_valid & auto_in_a_ready;
  assign head   = fifo_q[rd_ptr_q];
  assign auto_in_d_valid = (count_q != 2'd0);
  assign d_fire = auto_in_d_valid & auto_in_d_ready;

  assign auto_in_d_bits_opcode  = auto_in_d_valid ? head.opcode  : 3'd0;
  assign auto_in_d_bits_size    = auto_in_d_valid ? head.size    : 3'd0;
  assign auto_in_d_bits_source  = auto_in_d_valid ? head.source  : 2'd0;
  assign auto_in_d_bits_denied  = auto_in_d_valid ? head.denied  : 1'b0;
  assign auto_in_d_bits_corrupt = auto_in_d_valid ? head.corrupt : 1'b0;
  assign auto_in_d_bits_data    = auto_in_d_valid ? head.data    : 32'd0;

  always_comb begin
    offset   = auto_in_a_bits_address - BASE_ADDR;
    in_range = (auto_in_a_bits_address >= BASE_ADDR) && (offset < SPAN);
    case (auto_in_a_bits_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (offset[0] == 1'b0);
      3'd2:    aligned = (offset[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = in_range & aligned;
    idx   = offset[AW+1:2];

    rsp         = '0;
    rsp.size    = auto_in_a_bits_size;
    rsp.source  = auto_in_a_bits_source;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    case (auto_in_a_bits_opcode)
      3'd0, 3'd1: begin
        rsp.opcode = 3'd0;
        rsp.denied = ~legal;
        if (a_fire && legal) begin
          for (int b = 0; b < 4; b++)
            if (auto_in_a_bits_mask[b]) mem_d[idx][8*b +: 8] = auto_in_a_bits_data[8*b +: 8];
        end
      end
      3'd4: begin
        rsp.opcode  = 3'd1;
        rsp.denied  = ~legal;
        rsp.corrupt = ~legal;
        rsp.data    = legal ? mem_q[idx] : 32'd0;
      end
      3'd2, 3'd3: begin
        rsp.opcode  = 3'd1;
        rsp.denied  = 1'b1;
        rsp.corrupt = 1'b1;
      end
      3'd5:    rsp.opcode = 3'd2;
      default: begin
        rsp.opcode = 3'd0;
        rsp.denied = 1'b1;
      end
    endcase

    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (a_fire) begin
      fifo_d[wr_ptr_q] = rsp;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (d_fire) rd_ptr_d = ~rd_ptr_q;
    case ({a_fire, d_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ready_en_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_en_q <= 1'b1;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: doc/tl_ram_responder.md
# tl_ram_responder

TileLink-UL manager endpoint that terminates an A/D link: it accepts Get, PutFullData and PutPartialData requests on channel A, services them against a small internal word-addressed register array, and returns AccessAckData/AccessAck on channel D. It sits at the far end of a TileLink crossbar branch, below pass-through adapter and monitor nodes, using the same 32-bit data, 2-bit source and 3-bit size field layout. Responses are buffered in a 2-entry in-order queue, so the block decouples A acceptance from D back-pressure.

## Interface
- BASE_ADDR, 32'h6000_0000, byte address of word 0; must be aligned to 4*DEPTH
- DEPTH, 16, number of 32-bit words; power of two, 2..256
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- auto_in_a_valid / auto_in_a_ready  in / out  1  A handshake
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get, others unsupported
- auto_in_a_bits_param  in  3  ignored
- auto_in_a_bits_size  in  3  log2 bytes
- auto_in_a_bits_source  in  2  echoed on D
- auto_in_a_bits_address  in  32  byte address
- auto_in_a_bits_mask  in  4  byte lanes to write
- auto_in_a_bits_data  in  32  write data
- auto_in_a_bits_corrupt  in  1  ignored
- auto_in_d_valid / auto_in_d_ready  out / in  1  D handshake
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData, 2=HintAck
- auto_in_d_bits_size / _source  out  3 / 2  echo of request
- auto_in_d_bits_denied  out  1  request rejected
- auto_in_d_bits_data  out  32  read data; 0 when not AccessAckData or denied
- auto_in_d_bits_corrupt  out  1  set only with denied AccessAckData

## Operation
- A fire = a_valid & a_ready. a_ready = (count < 2); no enqueue while full, even if D fires the same cycle.
- Decode on fire: in_range = BASE_ADDR <= address < BASE_ADDR+4*DEPTH; aligned = address low bits aligned to size; legal = in_range & aligned & size<=2.
- Get (4): response AccessAckData; legal -> data = mem[(address-BASE_ADDR)>>2], denied=0, corrupt=0; illegal -> data=0, denied=1, corrupt=1.
- PutFull/PutPartial (0/1): legal -> mem word updated for each lane with mask[i]=1, at the fire edge; response AccessAck, denied=0. Illegal -> no write, AccessAck denied=1.
- Arithmetic/Logical (2/3): no write; AccessAckData, data=0, denied=1, corrupt=1.
- Hint (5): HintAck, denied=0. Opcodes 6/7: AccessAck, denied=1.
- Response pushed into 2-entry FIFO {opcode,size,source,denied,corrupt,data}; read data captured at enqueue, so ordering is strictly in acceptance order (a Get after a Put to same word returns new data).
- D head presented while count>0; pop on d_valid & d_ready. count: +1 on fire only, -1 on pop only, unchanged on both.

## Timing
- Reset (reset=0): count=0, pointers=0, mem all zero; a_ready=0 during reset, 1 from first edge after release; d_valid=0, all d_bits=0.
- Latency: request fired at edge N -> d_valid=1 with its response after edge N (1 cycle), if queue empty.
- Throughput: 1 request/cycle with d_ready held 1; with d_ready=0 two requests accepted, then a_ready=0.
- d_bits stable while d_valid & !d_ready.
- Reset asserted mid-transaction: queued responses discarded, d_valid drops asynchronously, memory cleared.
- Pointers wrap mod 2; count never exceeds 2.

## Test plan
- PutFull addr BASE+8, data 32'hDEADBEEF, mask 4'hF, source 1; then Get BASE+8 source 2 -> AccessAck src1 denied0, then AccessAckData src2 data 32'hDEADBEEF, each 1 cycle after acceptance.
- PutPartial BASE+8 mask 4'b0010 data 32'h0000_5500 after above; Get -> 32'hDEAD55EF.
- Get BASE+4*DEPTH (out of range) and Get BASE+2 size 2 (misaligned) -> AccessAckData denied1 corrupt1 data 0; memory unchanged.
- d_ready=0, issue 3 back-to-back Gets -> two accepted, a_ready=0 on third; release d_ready -> responses in order, third accepted the cycle after count drops to 1.
- Hint opcode 5 -> HintAck denied0; opcode 2 -> AccessAckData denied1; opcode 6 -> AccessAck denied1.
- Assert reset with 2 queued responses -> d_valid=0 immediately; after release Get BASE+8 -> data 0.
